// File: rtl/ip_sram_responder.sv
// Responder end of the cartridge RAM interface: runs one level-signalled request
// as a single strobed byte access on an external 8-bit asynchronous SRAM/flash bus.
module ip_sram_responder #(
    parameter int unsigned wait_cycles = 3
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rd,
    input  logic        wr,
    output logic        busy,
    input  logic [21:0] address,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_en,
    output logic [21:0] sram_a,
    output logic [7:0]  sram_d_out,
    output logic        sram_d_oe,
    input  logic [7:0]  sram_d_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(wait_cycles - 1);

    logic [1:0] state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       dir_rd, dir_rd_nx;
    logic       accept;
    logic       sample;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        dir_rd_nx = dir_rd;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (rd || wr) begin
                    accept    = 1'b1;
                    state_nx  = ACCESS;
                    dir_rd_nx = rd;
                    cnt_nx    = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nx = HOLD;
                    sample   = dir_rd;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HOLD: state_nx = RELEASE;
            RELEASE: begin
                if (!rd && !wr)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they change exactly on
    // the state transition edge with no combinational path from the request.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dir_rd     <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
            rdata_en   <= 1'b0;
            sram_a     <= '0;
            sram_d_out <= '0;
            sram_d_oe  <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dir_rd    <= dir_rd_nx;
            busy      <= (state_nx != IDLE);
            sram_ce_n <= (state_nx != ACCESS);
            sram_oe_n <= !((state_nx == ACCESS) && dir_rd_nx);
            sram_we_n <= !((state_nx == ACCESS) && !dir_rd_nx);
            sram_d_oe <= ((state_nx == ACCESS) || (state_nx == HOLD)) && !dir_rd_nx;
            rdata_en  <= (state_nx == HOLD) && dir_rd_nx;
            if (accept) begin
                sram_a <= address;
                if (!rd)
                    sram_d_out <= wdata;
            end
            if (sample)
                rdata <= sram_d_in;
        end
    end

endmodule

// File: tb/tb_ip_sram_responder.sv
// Bench for ip_sram_responder: two instances (3 and 1 strobe cycles) share the
// request inputs; each drives its own SRAM model and is checked against a memory reference.
module tb_ip_sram_responder;

    localparam int W0 = 3;
    localparam int W1 = 1;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [21:0] address = '0;
    logic [7:0]  wdata = '0;

    logic        busy[2], rdata_en[2], d_oe[2], ce_n[2], oe_n[2], we_n[2];
    logic [7:0]  rdata[2], d_out[2], d_in[2];
    logic [21:0] sa[2];

    always #5 clk = ~clk;

    ip_sram_responder #(.wait_cycles(W0)) u_w3 (
        .clk(clk), .n_reset(n_reset), .rd(rd), .wr(wr), .busy(busy[0]),
        .address(address), .wdata(wdata), .rdata(rdata[0]), .rdata_en(rdata_en[0]),
        .sram_a(sa[0]), .sram_d_out(d_out[0]), .sram_d_oe(d_oe[0]), .sram_d_in(d_in[0]),
        .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0])
    );

    ip_sram_responder #(.wait_cycles(W1)) u_w1 (
        .clk(clk), .n_reset(n_reset), .rd(rd), .wr(wr), .busy(busy[1]),
        .address(address), .wdata(wdata), .rdata(rdata[1]), .rdata_en(rdata_en[1]),
        .sram_a(sa[1]), .sram_d_out(d_out[1]), .sram_d_oe(d_oe[1]), .sram_d_in(d_in[1]),
        .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1])
    );

    // Unwritten locations hold a fixed address-derived pattern (0x012345 -> 0xA5).
    function automatic logic [7:0] dflt(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hC2;
    endfunction

    function automatic int wv(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    // External SRAM chips
    logic [7:0] mem0[logic [21:0]];
    logic [7:0] mem1[logic [21:0]];

    always @(negedge clk) begin
        d_in[0] = (!ce_n[0] && !oe_n[0]) ? (mem0.exists(sa[0]) ? mem0[sa[0]] : dflt(sa[0])) : 8'hEE;
        d_in[1] = (!ce_n[1] && !oe_n[1]) ? (mem1.exists(sa[1]) ? mem1[sa[1]] : dflt(sa[1])) : 8'hEE;
    end

    always @(posedge clk) begin
        if (!ce_n[0] && !we_n[0]) mem0[sa[0]] = d_out[0];
        if (!ce_n[1] && !we_n[1]) mem1[sa[1]] = d_out[1];
    end

    function automatic int chip_byte(input int i, input logic [21:0] a);
        if (i == 0) return mem0.exists(a) ? int'(mem0[a]) : int'(dflt(a));
        return mem1.exists(a) ? int'(mem1[a]) : int'(dflt(a));
    endfunction

    // Pin activity monitor, sampled 1 time unit after each rising edge
    int cyc = 0;
    int n_ce[2], n_oe[2], n_we[2], n_doe[2], n_en[2], n_win[2], n_bad[2], run[2];
    int en_edge[2], busy_fall[2], en_data[2];
    bit prev_ce[2] = '{1'b1, 1'b1};
    bit prev_busy[2];

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ce_n[i] === 1'b0) begin
                n_ce[i]++;
                run[i]++;
                if (prev_ce[i]) n_win[i]++;
            end else begin
                if (run[i] != 0 && run[i] != wv(i)) n_bad[i]++;
                run[i] = 0;
            end
            prev_ce[i] = (ce_n[i] !== 1'b0);
            if (oe_n[i] === 1'b0) n_oe[i]++;
            if (we_n[i] === 1'b0) n_we[i]++;
            if (d_oe[i] === 1'b1) n_doe[i]++;
            if (rdata_en[i] === 1'b1) begin
                n_en[i]++;
                en_edge[i] = cyc;
                en_data[i] = int'(rdata[i]);
            end
            if (prev_busy[i] && busy[i] === 1'b0) busy_fall[i] = cyc;
            prev_busy[i] = (busy[i] === 1'b1);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the memory should contain after the requests issued so far
    logic [7:0] ref_mem[logic [21:0]];
    int exp_rdata = 0;
    int exp_dout = 0;

    function automatic int ref_rd(input logic [21:0] a);
        return ref_mem.exists(a) ? int'(ref_mem[a]) : int'(dflt(a));
    endfunction

    int s_ce[2], s_oe[2], s_we[2], s_doe[2], s_en[2], s_win[2], s_bad[2];

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_ce[i] = n_ce[i]; s_oe[i] = n_oe[i]; s_we[i] = n_we[i]; s_doe[i] = n_doe[i];
            s_en[i] = n_en[i]; s_win[i] = n_win[i]; s_bad[i] = n_bad[i];
        end
    endtask

    // One request held for `hold` accepting edges, then checked on both instances
    task automatic do_req(input bit r, input bit w, input logic [21:0] a,
                          input logic [7:0] d, input int hold);
        int acc;
        int rel;
        string p;
        snap();
        @(negedge clk);
        rd = r; wr = w; address = a; wdata = d;
        acc = cyc + 1;
        repeat (hold) @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        address = 22'($urandom); wdata = 8'($urandom);
        for (int t = 0; t < 64 && (busy[0] !== 1'b0 || busy[1] !== 1'b0); t++)
            @(negedge clk);
        chk("idle_timeout", int'(busy[0] === 1'b0 && busy[1] === 1'b0), 1);
        @(negedge clk);
        if (r) exp_rdata = ref_rd(a);
        else begin
            ref_mem[a] = d;
            exp_dout = int'(d);
        end
        for (int i = 0; i < 2; i++) begin
            p = $sformatf("w%0d_a%06h_", wv(i), a);
            rel = (hold > wv(i) + 2) ? hold : wv(i) + 2;
            chk({p, "ce_windows"}, n_win[i] - s_win[i], 1);
            chk({p, "bad_window_len"}, n_bad[i] - s_bad[i], 0);
            chk({p, "ce_cycles"}, n_ce[i] - s_ce[i], wv(i));
            chk({p, "oe_cycles"}, n_oe[i] - s_oe[i], r ? wv(i) : 0);
            chk({p, "we_cycles"}, n_we[i] - s_we[i], r ? 0 : wv(i));
            chk({p, "d_oe_cycles"}, n_doe[i] - s_doe[i], r ? 0 : wv(i) + 1);
            chk({p, "rdata_en_pulses"}, n_en[i] - s_en[i], r ? 1 : 0);
            if (r) begin
                chk({p, "rdata_en_edge"}, en_edge[i] - acc, wv(i));
                chk({p, "rdata_at_en"}, en_data[i], exp_rdata);
            end else begin
                chk({p, "chip_byte"}, chip_byte(i, a), int'(d));
            end
            chk({p, "rdata_hold"}, int'(rdata[i]), exp_rdata);
            chk({p, "sram_a"}, int'(sa[i]), int'(a));
            chk({p, "sram_d_out"}, int'(d_out[i]), exp_dout);
            chk({p, "busy_release_edge"}, busy_fall[i] - acc, rel);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         r, w;
        int         kind;
        logic [21:0] a;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("w%0d_reset_busy", wv(i)), int'(busy[i]), 0);
            chk($sformatf("w%0d_reset_rdata", wv(i)), int'(rdata[i]), 0);
            chk($sformatf("w%0d_reset_rdata_en", wv(i)), int'(rdata_en[i]), 0);
            chk($sformatf("w%0d_reset_sram_a", wv(i)), int'(sa[i]), 0);
            chk($sformatf("w%0d_reset_d_out", wv(i)), int'(d_out[i]), 0);
            chk($sformatf("w%0d_reset_d_oe", wv(i)), int'(d_oe[i]), 0);
            chk($sformatf("w%0d_reset_strobes", wv(i)), int'({ce_n[i], oe_n[i], we_n[i]}), 7);
        end
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1'b1, 1'b0, 22'h012345, 8'h00, 8);
        chk("read_012345_a5", int'(rdata[0]), 8'hA5);
        do_req(1'b0, 1'b1, 22'h3FFFFF, 8'h5A, 2);
        chk("write_3fffff_chip", chip_byte(0, 22'h3FFFFF), 8'h5A);
        do_req(1'b1, 1'b0, 22'h3FFFFF, 8'h00, 20);
        do_req(1'b1, 1'b0, 22'h3FFFFF, 8'h00, 1);
        chk("reread_3fffff", int'(rdata[0]), 8'h5A);
        do_req(1'b1, 1'b1, 22'h000100, 8'h77, 3);
        do_req(1'b1, 1'b0, 22'h000010, 8'h00, 1);
        do_req(1'b1, 1'b0, 22'h000011, 8'h00, 1);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            r = (kind != 1);
            w = (kind == 1 || kind == 2);
            a = 22'h2A0000 | 22'($urandom_range(0, 7));
            do_req(r, w, a, 8'($urandom), int'($urandom_range(1, 7)));
        end

        // Reset during the second of three strobe cycles of a read
        snap();
        @(negedge clk);
        rd = 1'b1; address = 22'h012345;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_oe_low", int'(oe_n[0]), 0);
        #1;
        n_reset = 1'b0;
        #1;
        chk("reset_mid_ce_n", int'(ce_n[0]), 1);
        chk("reset_mid_oe_n", int'(oe_n[0]), 1);
        chk("reset_mid_busy", int'(busy[0]), 0);
        chk("reset_mid_rdata", int'(rdata[0]), 0);
        @(negedge clk);
        rd = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("reset_mid_no_rdata_en", n_en[0] - s_en[0], 0);
        chk("reset_after_rdata", int'(rdata[0]), 0);
        chk("reset_after_busy", int'(busy[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
